matmul_sequencer: RTL and testbench
===================================

// Module: matmul_sequencer
// PURPOSE
//  Controller that sequences a full C = A x B single-precision float multiply
//  through the row-parallel matrix multiplier datapath (COLS_B mult/add lanes).
//  Fetches A cells and B rows from a word memory, issues them to the datapath,
//  captures each finished C row and writes it to a row-wide result memory.
//  Sits between the coprocessor command decoder (start/done) and the datapath.
// PARAMETERS
//  ROWS_A  2   rows of A = rows of C
//  COLS_A  2   cols of A = rows of B = accumulations per C row
//  COLS_B  2   cols of B = datapath lanes = words per B/C row
//  AW      10  word address width (operand and result memories)
// PORTS
//  clk         in   1          clock, all logic on posedge
//  rst         in   1          synchronous, active-high reset
//  start       in   1          1-cycle pulse, begin job (ignored when busy=1)
//  a_base      in   AW         word address of A[0][0], latched on start
//  b_base      in   AW         word address of B[0][0], latched on start
//  r_base      in   AW         row address of C row 0, latched on start
//  busy        out  1          high from cycle after accepted start until done
//  done        out  1          1-cycle pulse after last C row written
//  mem_rd_en   out  1          operand read request
//  mem_addr    out  AW         operand read address
//  mem_rdata   in   32         read data, valid exactly 1 cycle after mem_rd_en
//  mm_cell     out  32         A[i][k] to datapath
//  mm_cell_stb out  1          cell valid
//  mm_row      out  32*COLS_B  B row k, lane j at [j*32 +: 32]
//  mm_row_stb  out  1          row valid
//  mm_ready    in   1          1-cycle pulse: datapath consumed cell+row
//  mm_out_row  in   32*COLS_B  finished C row from datapath
//  mm_out_stb  in   1          1-cycle pulse: mm_out_row valid
//  res_we      out  1          result row write strobe (1 cycle)
//  res_addr    out  AW         result row address = r_base + i
//  res_wdata   out  32*COLS_B  C row i
// BEHAVIOUR
//  - Reset: state IDLE; busy, done, mem_rd_en, mm_cell_stb, mm_row_stb, res_we
//    = 0; mem_addr, mm_cell, mm_row, res_addr, res_wdata = 0; i, k, j = 0;
//    out_pending = 0. Reset mid-job abandons job immediately, no write/done.
//  - Layout: A[i][k] at a_base + i*COLS_A + k; B[k][j] at b_base + k*COLS_B + j.
//  - FSM: IDLE -start-> FETCH_A -> FETCH_B -> ISSUE -> (k<COLS_A-1: FETCH_A,
//    k+1) | (k==COLS_A-1: WAIT_OUT) -> WRITE -> (i<ROWS_A-1: FETCH_A, i+1, k=0)
//    | (i==ROWS_A-1: DONE) -> IDLE.
//  - FETCH_A: 1 read cycle, capture mem_rdata into mm_cell next cycle (2 cycles).
//  - FETCH_B: COLS_B back-to-back reads, j=0..COLS_B-1; word j captured into
//    lane j one cycle later; state exits the cycle the last word is captured.
//  - ISSUE: mm_cell_stb=mm_row_stb=1, operands held stable, until cycle mm_ready
//    is sampled 1; strobes drop the following cycle. mm_ready outside ISSUE ignored.
//  - mm_out_stb sampled in any busy state: mm_out_row latched into res_wdata,
//    out_pending=1 (datapath may finish before FSM reaches WAIT_OUT).
//  - WAIT_OUT: leave when out_pending=1. WRITE: res_we=1 one cycle,
//    res_addr=r_base+i, out_pending cleared. Second mm_out_stb while
//    out_pending=1 overwrites res_wdata (datapath protocol violation, no flag).
//  - DONE: done=1 one cycle, busy drops same cycle-edge as done rises->falls.
//  - start while busy: ignored, bases not relatched. start with rst: rst wins.
//  - Address arithmetic modulo 2^AW (wraps, no error).
//  - Per accumulation step latency: 2 + COLS_B + 1 + (mm_ready wait) cycles.
// TESTING
//  1 2x2: A=[[1,2],[3,4]] B=[[5,6],[7,8]] (IEEE754), behavioural datapath model
//    -> res rows {19.0,22.0}=0x41980000,0x41B00000 and {43.0,50.0}=0x422C0000,
//    0x42480000 at r_base, r_base+1; exactly 2 res_we, 1 done pulse.
//  2 Read order a_base=0x10,b_base=0x20: mem_addr seq 0x10,0x20,0x21,0x11,0x22,
//    0x23,0x12,... ; mm_ready delayed 5 cycles -> strobes/operands held stable.
//  3 mm_out_stb arrives before FSM reaches WAIT_OUT -> row still written once,
//    correct data, no hang.
//  4 rst asserted during ISSUE of row 1 -> next cycle all outputs 0, IDLE;
//    new start runs full job correctly.
//  5 start pulsed while busy with different bases -> ignored, results at
//    original r_base; a_base=2^AW-1 -> read addresses wrap to 0.

Source files
------------

// File: rtl/matmul_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : matmul_sequencer_if
// Purpose  : Command, operand-memory, datapath and result-memory signals of the
//            matmul sequencer. Suffixes give direction as seen by the sequencer.
// Revision : 1.0
// ============================================================================
interface matmul_sequencer_if #(
  parameter int COLS_B = 2,
  parameter int AW     = 10
);
  logic                  start_i;
  logic [AW-1:0]         a_base_i;
  logic [AW-1:0]         b_base_i;
  logic [AW-1:0]         r_base_i;
  logic                  busy_o;
  logic                  done_o;
  logic                  mem_rd_en_o;
  logic [AW-1:0]         mem_addr_o;
  logic [31:0]           mem_rdata_i;
  logic [31:0]           mm_cell_o;
  logic                  mm_cell_stb_o;
  logic [32*COLS_B-1:0]  mm_row_o;
  logic                  mm_row_stb_o;
  logic                  mm_ready_i;
  logic [32*COLS_B-1:0]  mm_out_row_i;
  logic                  mm_out_stb_i;
  logic                  res_we_o;
  logic [AW-1:0]         res_addr_o;
  logic [32*COLS_B-1:0]  res_wdata_o;

  modport master (
    input  start_i, a_base_i, b_base_i, r_base_i,
    output busy_o, done_o,
    output mem_rd_en_o, mem_addr_o,
    input  mem_rdata_i,
    output mm_cell_o, mm_cell_stb_o, mm_row_o, mm_row_stb_o,
    input  mm_ready_i, mm_out_row_i, mm_out_stb_i,
    output res_we_o, res_addr_o, res_wdata_o
  );

  modport slave (
    output start_i, a_base_i, b_base_i, r_base_i,
    input  busy_o, done_o,
    input  mem_rd_en_o, mem_addr_o,
    output mem_rdata_i,
    input  mm_cell_o, mm_cell_stb_o, mm_row_o, mm_row_stb_o,
    output mm_ready_i, mm_out_row_i, mm_out_stb_i,
    input  res_we_o, res_addr_o, res_wdata_o
  );
endinterface
`default_nettype wire

// File: rtl/matmul_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : matmul_sequencer
// Purpose  : Sequences C = A x B through the row-parallel FP multiplier datapath:
//            fetches A cells / B rows, issues them, writes finished C rows.
// Revision : 1.0
// ============================================================================
module matmul_sequencer #(
  parameter int ROWS_A = 2,
  parameter int COLS_A = 2,
  parameter int COLS_B = 2,
  parameter int AW     = 10
) (
  input  wire logic          clk,
  input  wire logic          rst,
  matmul_sequencer_if.master bus
);

  localparam int IW = (ROWS_A > 1) ? $clog2(ROWS_A) : 1;
  localparam int KW = (COLS_A > 1) ? $clog2(COLS_A) : 1;
  localparam int JW = $clog2(COLS_B + 1);
  localparam int RW = 32 * COLS_B;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_FETCH_A  = 3'd1,
    S_FETCH_B  = 3'd2,
    S_ISSUE    = 3'd3,
    S_WAIT_OUT = 3'd4,
    S_WRITE    = 3'd5,
    S_DONE     = 3'd6
  } state_t;

  state_t        state_q;
  logic [AW-1:0] a_base_q, b_base_q, r_base_q;
  logic [IW-1:0] i_q;
  logic [KW-1:0] k_q;
  logic [JW-1:0] j_q;
  logic          out_pending_q;
  logic          busy_q, done_q;
  logic          mem_rd_en_q;
  logic [AW-1:0] mem_addr_q;
  logic [31:0]   mm_cell_q;
  logic          mm_cell_stb_q, mm_row_stb_q;
  logic [RW-1:0] mm_row_q;
  logic          res_we_q;
  logic [AW-1:0] res_addr_q;
  logic [RW-1:0] res_wdata_q;

  // Row-major layouts; sums deliberately truncate to AW bits so addresses wrap.
  function automatic logic [AW-1:0] a_addr(input logic [AW-1:0] base, input int ii, input int kk);
    return base + AW'(ii * COLS_A + kk);
  endfunction

  function automatic logic [AW-1:0] b_addr(input logic [AW-1:0] base, input int kk, input int jj);
    return base + AW'(kk * COLS_B + jj);
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      a_base_q      <= '0;
      b_base_q      <= '0;
      r_base_q      <= '0;
      i_q           <= '0;
      k_q           <= '0;
      j_q           <= '0;
      out_pending_q <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      mem_rd_en_q   <= 1'b0;
      mem_addr_q    <= '0;
      mm_cell_q     <= '0;
      mm_cell_stb_q <= 1'b0;
      mm_row_stb_q  <= 1'b0;
      mm_row_q      <= '0;
      res_we_q      <= 1'b0;
      res_addr_q    <= '0;
      res_wdata_q   <= '0;
    end else begin
      // The datapath may finish a row before the FSM reaches WAIT_OUT.
      if (busy_q && bus.mm_out_stb_i) begin
        res_wdata_q   <= bus.mm_out_row_i;
        out_pending_q <= 1'b1;
      end

      case (state_q)
        S_IDLE: begin
          if (bus.start_i) begin
            a_base_q    <= bus.a_base_i;
            b_base_q    <= bus.b_base_i;
            r_base_q    <= bus.r_base_i;
            busy_q      <= 1'b1;
            i_q         <= '0;
            k_q         <= '0;
            j_q         <= '0;
            mem_rd_en_q <= 1'b1;
            mem_addr_q  <= a_addr(bus.a_base_i, 0, 0);
            state_q     <= S_FETCH_A;
          end
        end

        S_FETCH_A: begin
          if (j_q == '0) begin
            mem_rd_en_q <= 1'b0;
            j_q         <= JW'(1);
          end else begin
            mm_cell_q   <= bus.mem_rdata_i;
            j_q         <= '0;
            mem_rd_en_q <= 1'b1;
            mem_addr_q  <= b_addr(b_base_q, int'(k_q), 0);
            state_q     <= S_FETCH_B;
          end
        end

        // j_q counts the read being issued; word j_q-1 lands this cycle.
        S_FETCH_B: begin
          if (j_q != '0) begin
            mm_row_q[32*(int'(j_q)-1) +: 32] <= bus.mem_rdata_i;
          end
          if (int'(j_q) + 1 < COLS_B) begin
            mem_rd_en_q <= 1'b1;
            mem_addr_q  <= b_addr(b_base_q, int'(k_q), int'(j_q) + 1);
          end else begin
            mem_rd_en_q <= 1'b0;
          end
          if (int'(j_q) == COLS_B) begin
            j_q           <= '0;
            mm_cell_stb_q <= 1'b1;
            mm_row_stb_q  <= 1'b1;
            state_q       <= S_ISSUE;
          end else begin
            j_q <= j_q + JW'(1);
          end
        end

        S_ISSUE: begin
          if (bus.mm_ready_i) begin
            mm_cell_stb_q <= 1'b0;
            mm_row_stb_q  <= 1'b0;
            if (int'(k_q) < COLS_A - 1) begin
              k_q         <= k_q + KW'(1);
              mem_rd_en_q <= 1'b1;
              mem_addr_q  <= a_addr(a_base_q, int'(i_q), int'(k_q) + 1);
              state_q     <= S_FETCH_A;
            end else begin
              state_q <= S_WAIT_OUT;
            end
          end
        end

        S_WAIT_OUT: begin
          if (out_pending_q) begin
            res_we_q   <= 1'b1;
            res_addr_q <= r_base_q + AW'(int'(i_q));
            state_q    <= S_WRITE;
          end
        end

        S_WRITE: begin
          res_we_q      <= 1'b0;
          out_pending_q <= 1'b0;
          if (int'(i_q) < ROWS_A - 1) begin
            i_q         <= i_q + IW'(1);
            k_q         <= '0;
            mem_rd_en_q <= 1'b1;
            mem_addr_q  <= a_addr(a_base_q, int'(i_q) + 1, 0);
            state_q     <= S_FETCH_A;
          end else begin
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end
        end

        S_DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end

        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.busy_o        = busy_q;
  assign bus.done_o        = done_q;
  assign bus.mem_rd_en_o   = mem_rd_en_q;
  assign bus.mem_addr_o    = mem_addr_q;
  assign bus.mm_cell_o     = mm_cell_q;
  assign bus.mm_cell_stb_o = mm_cell_stb_q;
  assign bus.mm_row_o      = mm_row_q;
  assign bus.mm_row_stb_o  = mm_row_stb_q;
  assign bus.res_we_o      = res_we_q;
  assign bus.res_addr_o    = res_addr_q;
  assign bus.res_wdata_o   = res_wdata_q;

endmodule
`default_nettype wire

// File: tb/tb_matmul_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_matmul_sequencer
// Purpose  : Directed bench for matmul_sequencer with memory and datapath models.
// Revision : 1.0
// ============================================================================
module tb_matmul_sequencer;
  localparam int ROWS_A = 2;
  localparam int COLS_A = 2;
  localparam int COLS_B = 2;
  localparam int AW     = 10;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  matmul_sequencer_if #(.COLS_B(COLS_B), .AW(AW)) bus ();
  matmul_sequencer #(.ROWS_A(ROWS_A), .COLS_A(COLS_A), .COLS_B(COLS_B), .AW(AW))
    u_dut (.clk(clk), .rst(rst), .bus(bus));

  int total = 0;
  int bad   = 0;

  logic [31:0]   mem     [0:1023];
  logic [63:0]   res_mem [0:1023];
  logic [AW-1:0] exp_addr[$];
  logic [31:0]   exp_cell[$];
  logic [63:0]   exp_row[$];
  logic [AW-1:0] exp_raddr[$];
  logic [63:0]   exp_rdata[$];
  logic [AW-1:0] rd_log[$];
  int done_cnt = 0;
  int we_cnt   = 0;
  bit job_on   = 1'b0;
  int ready_dly = 0;
  int out_dly   = 2;
  int A[2][2];
  int B[2][2];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  task automatic bad_evt(input string name);
    total++;
    bad++;
    $display("FAIL %s: got unexpected event, required none", name);
  endtask

  function automatic logic [31:0] i2f(input int v);
    int m;
    logic [31:0] t;
    if (v <= 0) return 32'h0;
    m = 30;
    while (((v >> m) & 1) == 0) m--;
    t = 32'(v) << (23 - m);
    return {1'b0, 8'(127 + m), t[22:0]};
  endfunction

  function automatic int f2i(input logic [31:0] f);
    int e;
    logic [31:0] mnt;
    if (f[30:0] == 31'h0) return 0;
    e   = int'(f[30:23]) - 127;
    mnt = {8'h0, 1'b1, f[22:0]};
    return int'(mnt >> (23 - e));
  endfunction

  // Operand memory: word returned the cycle after the read request.
  initial begin
    logic          s_rd;
    logic [AW-1:0] s_addr;
    bus.mem_rdata_i = 32'h0;
    forever begin
      @(posedge clk);
      s_rd   = bus.mem_rd_en_o;
      s_addr = bus.mem_addr_o;
      #1;
      bus.mem_rdata_i = s_rd ? mem[s_addr] : 32'h0;
    end
  end

  // Datapath: accepts each cell+row after ready_dly strobe cycles, accumulates
  // integer-valued floats, emits the C row out_dly cycles after the last step.
  initial begin
    int wcnt, kacc, ocnt;
    int acc[COLS_B];
    logic [63:0] pend_row;
    logic s_rst;
    wcnt = 0; kacc = 0; ocnt = -1; pend_row = '0;
    foreach (acc[j]) acc[j] = 0;
    bus.mm_ready_i   = 1'b0;
    bus.mm_out_stb_i = 1'b0;
    bus.mm_out_row_i = '0;
    forever begin
      @(posedge clk);
      s_rst = rst;
      #1;
      bus.mm_ready_i   = 1'b0;
      bus.mm_out_stb_i = 1'b0;
      if (s_rst) begin
        wcnt = 0; kacc = 0; ocnt = -1;
        foreach (acc[j]) acc[j] = 0;
        continue;
      end
      if (bus.mm_cell_stb_o) begin
        if (wcnt >= ready_dly) begin
          bus.mm_ready_i = 1'b1;
          wcnt = 0;
          for (int j = 0; j < COLS_B; j++)
            acc[j] += f2i(bus.mm_cell_o) * f2i(bus.mm_row_o[j*32 +: 32]);
          kacc++;
          if (kacc == COLS_A) begin
            for (int j = 0; j < COLS_B; j++) begin
              pend_row[j*32 +: 32] = i2f(acc[j]);
              acc[j] = 0;
            end
            kacc = 0;
            ocnt = out_dly;
          end
        end else begin
          wcnt++;
        end
      end
      if (ocnt == 0) begin
        bus.mm_out_stb_i = 1'b1;
        bus.mm_out_row_i = pend_row;
        ocnt = -1;
      end else if (ocnt > 0) begin
        ocnt--;
      end
    end
  end

  // Compare process: every output event checked against the expected streams.
  always @(negedge clk) begin
    if (!rst) begin
      if (job_on && !bus.done_o) chk("busy_high", 64'(bus.busy_o), 64'd1);
      if (bus.mem_rd_en_o) begin
        rd_log.push_back(bus.mem_addr_o);
        if (exp_addr.size() == 0) bad_evt("rd_extra");
        else chk("rd_addr", 64'(bus.mem_addr_o), 64'(exp_addr.pop_front()));
      end
      if (bus.mm_cell_stb_o) begin
        chk("row_stb", 64'(bus.mm_row_stb_o), 64'd1);
        if (exp_cell.size() == 0) bad_evt("issue_extra");
        else begin
          chk("mm_cell", 64'(bus.mm_cell_o), 64'(exp_cell[0]));
          chk("mm_row", 64'(bus.mm_row_o), exp_row[0]);
          if (bus.mm_ready_i) begin
            void'(exp_cell.pop_front());
            void'(exp_row.pop_front());
          end
        end
      end
      if (bus.res_we_o) begin
        we_cnt++;
        res_mem[bus.res_addr_o] = bus.res_wdata_o;
        if (exp_raddr.size() == 0) bad_evt("res_we_extra");
        else begin
          chk("res_addr", 64'(bus.res_addr_o), 64'(exp_raddr.pop_front()));
          chk("res_wdata", bus.res_wdata_o, exp_rdata.pop_front());
        end
      end
      if (bus.done_o) begin
        done_cnt++;
        job_on = 1'b0;
      end
    end
  end

  // Loads A/B into memory at their layouts and builds every expected stream.
  task automatic prep_job(input int ab, input int bb, input int rb);
    logic [63:0] r;
    int c;
    for (int i = 0; i < ROWS_A; i++)
      for (int k = 0; k < COLS_A; k++)
        mem[(ab + i*COLS_A + k) % 1024] = i2f(A[i][k]);
    for (int k = 0; k < COLS_A; k++)
      for (int j = 0; j < COLS_B; j++)
        mem[(bb + k*COLS_B + j) % 1024] = i2f(B[k][j]);
    for (int i = 0; i < ROWS_A; i++) begin
      for (int k = 0; k < COLS_A; k++) begin
        exp_addr.push_back(AW'((ab + i*COLS_A + k) % 1024));
        for (int j = 0; j < COLS_B; j++) begin
          exp_addr.push_back(AW'((bb + k*COLS_B + j) % 1024));
          r[j*32 +: 32] = i2f(B[k][j]);
        end
        exp_cell.push_back(i2f(A[i][k]));
        exp_row.push_back(r);
      end
      for (int j = 0; j < COLS_B; j++) begin
        c = 0;
        for (int k = 0; k < COLS_A; k++) c += A[i][k] * B[k][j];
        r[j*32 +: 32] = i2f(c);
      end
      exp_raddr.push_back(AW'((rb + i) % 1024));
      exp_rdata.push_back(r);
    end
  endtask

  task automatic pulse_start(input int ab, input int bb, input int rb);
    @(posedge clk); #1;
    bus.a_base_i = AW'(ab);
    bus.b_base_i = AW'(bb);
    bus.r_base_i = AW'(rb);
    bus.start_i  = 1'b1;
    @(posedge clk); #1;
    bus.start_i  = 1'b0;
  endtask

  task automatic start_job(input int ab, input int bb, input int rb);
    prep_job(ab, bb, rb);
    rd_log.delete();
    pulse_start(ab, bb, rb);
    job_on = 1'b1;
  endtask

  task automatic finish_job(input string tag);
    int d0, w0, n;
    d0 = done_cnt - 0;
    w0 = we_cnt;
    n = 0;
    while (job_on && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (job_on) begin
      bad_evt({tag, "_done_timeout"});
      job_on = 1'b0;
    end
    repeat (3) @(negedge clk);
    chk({tag, "_done_pulses"}, 64'(done_cnt), 64'(d0 + (n < 3000 ? 1 : 0)));
    chk({tag, "_rd_left"}, 64'(exp_addr.size()), 64'd0);
    chk({tag, "_res_left"}, 64'(exp_rdata.size()), 64'd0);
    chk({tag, "_busy_after"}, 64'(bus.busy_o), 64'd0);
    if (w0 < 0) bad_evt("unreachable");
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_busy"}, 64'(bus.busy_o), 64'd0);
    chk({tag, "_done"}, 64'(bus.done_o), 64'd0);
    chk({tag, "_rd_en"}, 64'(bus.mem_rd_en_o), 64'd0);
    chk({tag, "_cell_stb"}, 64'(bus.mm_cell_stb_o), 64'd0);
    chk({tag, "_row_stb"}, 64'(bus.mm_row_stb_o), 64'd0);
    chk({tag, "_res_we"}, 64'(bus.res_we_o), 64'd0);
    chk({tag, "_mem_addr"}, 64'(bus.mem_addr_o), 64'd0);
    chk({tag, "_cell"}, 64'(bus.mm_cell_o), 64'd0);
    chk({tag, "_row"}, bus.mm_row_o, 64'd0);
    chk({tag, "_res_addr"}, 64'(bus.res_addr_o), 64'd0);
    chk({tag, "_res_wdata"}, bus.res_wdata_o, 64'd0);
  endtask

  initial begin
    int w0, d0, n;
    bus.start_i  = 1'b0;
    bus.a_base_i = '0;
    bus.b_base_i = '0;
    bus.r_base_i = '0;
    for (int a = 0; a < 1024; a++) begin
      mem[a]     = 32'h0;
      res_mem[a] = 64'h0;
    end
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_idle("reset");

    // 1: basic 2x2, C row written after datapath delay
    A = '{'{1, 2}, '{3, 4}};
    B = '{'{5, 6}, '{7, 8}};
    ready_dly = 0; out_dly = 2;
    w0 = we_cnt;
    start_job(16'h10, 16'h20, 16'h100);
    finish_job("t1");
    chk("t1_we_count", 64'(we_cnt - w0), 64'd2);
    chk("t1_row0", res_mem[10'h100], 64'h41B00000_41980000);
    chk("t1_row1", res_mem[10'h101], 64'h42480000_422C0000);

    // 2: read order and held operands under slow mm_ready
    ready_dly = 5; out_dly = 1;
    start_job(16'h10, 16'h20, 16'h120);
    finish_job("t2");
    chk("t2_rd0", 64'(rd_log[0]), 64'h10);
    chk("t2_rd1", 64'(rd_log[1]), 64'h20);
    chk("t2_rd2", 64'(rd_log[2]), 64'h21);
    chk("t2_rd3", 64'(rd_log[3]), 64'h11);
    chk("t2_rd4", 64'(rd_log[4]), 64'h22);
    chk("t2_rd5", 64'(rd_log[5]), 64'h23);
    chk("t2_rd6", 64'(rd_log[6]), 64'h12);

    // 3: result arrives together with the final mm_ready, before WAIT_OUT
    ready_dly = 1; out_dly = 0;
    w0 = we_cnt;
    start_job(16'h10, 16'h20, 16'h140);
    finish_job("t3");
    chk("t3_we_count", 64'(we_cnt - w0), 64'd2);
    chk("t3_row1", res_mem[10'h141], 64'h42480000_422C0000);

    // 4: reset during row-1 issue abandons the job
    ready_dly = 5; out_dly = 1;
    w0 = we_cnt;
    d0 = done_cnt;
    start_job(16'h10, 16'h20, 16'h160);
    n = 0;
    while (we_cnt == w0 && n < 500) begin @(negedge clk); n++; end
    while (!bus.mm_cell_stb_o && n < 500) begin @(negedge clk); n++; end
    if (n >= 500) bad_evt("t4_reach_issue_timeout");
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    exp_addr.delete(); exp_cell.delete(); exp_row.delete();
    exp_raddr.delete(); exp_rdata.delete();
    job_on = 1'b0;
    @(negedge clk);
    check_idle("t4_abort");
    chk("t4_no_done", 64'(done_cnt), 64'(d0));
    chk("t4_one_write", 64'(we_cnt - w0), 64'd1);
    ready_dly = 0; out_dly = 1;
    start_job(16'h10, 16'h20, 16'h180);
    finish_job("t4_rerun");
    chk("t4_rerun_row0", res_mem[10'h180], 64'h41B00000_41980000);

    // 5: start while busy is ignored; A base wraps past the top of memory
    A = '{'{2, 0}, '{1, 3}};
    B = '{'{4, 1}, '{2, 5}};
    ready_dly = 2; out_dly = 1;
    start_job(16'h3FF, 16'h40, 16'h50);
    repeat (4) @(posedge clk);
    pulse_start(16'h200, 16'h210, 16'h300);
    finish_job("t5");
    chk("t5_rd0_top", 64'(rd_log[0]), 64'h3FF);
    chk("t5_rd3_wrap", 64'(rd_log[3]), 64'h000);
    chk("t5_row0", res_mem[10'h050], 64'h40000000_41000000);
    chk("t5_row1", res_mem[10'h051], 64'h41800000_41200000);
    chk("t5_no_reloc", res_mem[10'h300], 64'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
